// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared constants for the data-memory arbiter.
//   - FSM state encoding (IDLE / ACCESS / RESP)
//   - requester port identifiers (CPU load/store unit, debug/DMA)
package dm_arb_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: bundle of the two requester handshakes and the data-memory
// pins around dm_arbiter.
//   slave  : the arbiter's view (takes requests, drives done/rdata/dm_*/busy)
//   master : the environment's view (requesters plus memory read data)
interface dm_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic          rq0_req;
    logic          rq0_we;
    logic [AW-1:0] rq0_addr;
    logic [DW-1:0] rq0_wdata;
    logic          rq0_done;
    logic [DW-1:0] rq0_rdata;

    logic          rq1_req;
    logic          rq1_we;
    logic [AW-1:0] rq1_addr;
    logic [DW-1:0] rq1_wdata;
    logic          rq1_done;
    logic [DW-1:0] rq1_rdata;

    logic [AW-1:0] dm_addr;
    logic          dm_read;
    logic          dm_write;
    logic [DW-1:0] dm_wrt_data;
    logic [DW-1:0] dm_rd_data;

    logic          busy;

    modport slave (
        input  rq0_req, rq0_we, rq0_addr, rq0_wdata,
        input  rq1_req, rq1_we, rq1_addr, rq1_wdata,
        input  dm_rd_data,
        output rq0_done, rq0_rdata, rq1_done, rq1_rdata,
        output dm_addr, dm_read, dm_write, dm_wrt_data, busy
    );

    modport master (
        output rq0_req, rq0_we, rq0_addr, rq0_wdata,
        output rq1_req, rq1_we, rq1_addr, rq1_wdata,
        output dm_rd_data,
        input  rq0_done, rq0_rdata, rq1_done, rq1_rdata,
        input  dm_addr, dm_read, dm_write, dm_wrt_data, busy
    );

endinterface

// File: rtl/dm_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick.
//   req[1:0]  : request per port
//   ptr       : port that wins when both request
//   gnt_id    : chosen port
//   gnt_valid : at least one port requests
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       gnt_id,
    output logic       gnt_valid
);

    always_comb begin
        // NOTE: combinational outputs get a default first so no path leaves
        // them unassigned, which would otherwise infer a latch.
        gnt_id    = 1'b0;
        gnt_valid = |req;
        if (&req) gnt_id = ptr;   // contention: the pointer decides
        else      gnt_id = req[1]; // lone requester wins regardless of ptr
    end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares a single-port data memory between the CPU load/store
// unit (port 0) and a debug/DMA requester (port 1), round-robin, with a
// fixed read latency of LAT cycles (1..7).
//   clk  : rising-edge clock
//   rst  : synchronous, active-low reset
//   bus  : requester handshakes, memory pins and busy (slave view)
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int AW  = 8,
    parameter int DW  = 32,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    dm_arbiter_if.slave   bus
);

    generate
        if (LAT < 1 || LAT > 7) begin : g_bad_lat
            $error("dm_arbiter: LAT must be in 1..7");
        end
    endgenerate

    logic [1:0]    state;
    logic          ptr;
    logic [2:0]    cnt;
    logic          id_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    logic gnt_id;
    logic gnt_valid;

    rr_arb2 u_rr (
        .req       ({bus.rq1_req, bus.rq0_req}),
        .ptr       (ptr),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register sees the pre-edge values of the others.
        if (!rst) begin
            // NOTE: the latched request and rdata registers are plain flops,
            // reset so outputs read 0 after reset rather than stale data.
            state    <= IDLE;
            ptr      <= 1'b0;
            cnt      <= 3'd0;
            id_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        id_q    <= gnt_id;
                        we_q    <= gnt_id ? bus.rq1_we    : bus.rq0_we;
                        addr_q  <= gnt_id ? bus.rq1_addr  : bus.rq0_addr;
                        wdata_q <= gnt_id ? bus.rq1_wdata : bus.rq0_wdata;
                        cnt     <= 3'(LAT - 1);
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (we_q) begin
                        state <= RESP;
                    end else if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end else begin
                        // Last access cycle of a read: memory data is valid now.
                        if (id_q == PORT_DBG) rdata1_q <= bus.dm_rd_data;
                        else                  rdata0_q <= bus.dm_rd_data;
                        state <= RESP;
                    end
                end
                RESP: begin
                    ptr   <= ~id_q;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs depend only on registered state, never on request inputs.
    logic in_access;
    assign in_access = (state == ACCESS);

    assign bus.dm_addr     = in_access ? addr_q  : '0;
    assign bus.dm_wrt_data = in_access ? wdata_q : '0;
    assign bus.dm_write    = in_access &  we_q;
    assign bus.dm_read     = in_access & ~we_q;
    assign bus.busy        = (state != IDLE);

    assign bus.rq0_done  = (state == RESP) && (id_q == PORT_CPU);
    assign bus.rq1_done  = (state == RESP) && (id_q == PORT_DBG);
    assign bus.rq0_rdata = rdata0_q;
    assign bus.rq1_rdata = rdata1_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed self-checking bench for dm_arbiter.
// Two instances: LAT=1 (bus_a) and LAT=3 (bus_b). Inputs change and outputs
// are sampled 1 time unit after each rising edge.
module tb_dm_arbiter;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    dm_arbiter_if #(.AW(8), .DW(32)) bus_a ();
    dm_arbiter_if #(.AW(8), .DW(32)) bus_b ();

    // Memory models: read data is a fixed function of the address.
    assign bus_a.dm_rd_data = {16'hBEEF, 8'h00, bus_a.dm_addr};
    assign bus_b.dm_rd_data = (bus_b.dm_addr == 8'h20) ? 32'd99
                                                       : {16'hCAFE, 8'h00, bus_b.dm_addr};

    dm_arbiter #(.AW(8), .DW(32), .LAT(1)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
    dm_arbiter #(.AW(8), .DW(32), .LAT(3)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All outputs of one bus folded into one word: zero only when all are 0.
    function automatic logic [31:0] any_out_a();
        return {31'd0, bus_a.rq0_done | bus_a.rq1_done | bus_a.dm_read | bus_a.dm_write |
                bus_a.busy | (|bus_a.dm_addr) | (|bus_a.dm_wrt_data) |
                (|bus_a.rq0_rdata) | (|bus_a.rq1_rdata)};
    endfunction

    function automatic logic [31:0] any_out_b();
        return {31'd0, bus_b.rq0_done | bus_b.rq1_done | bus_b.dm_read | bus_b.dm_write |
                bus_b.busy | (|bus_b.dm_addr) | (|bus_b.dm_wrt_data) |
                (|bus_b.rq0_rdata) | (|bus_b.rq1_rdata)};
    endfunction

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        {bus_a.rq0_req, bus_a.rq0_we, bus_a.rq0_addr, bus_a.rq0_wdata} = '0;
        {bus_a.rq1_req, bus_a.rq1_we, bus_a.rq1_addr, bus_a.rq1_wdata} = '0;
        {bus_b.rq0_req, bus_b.rq0_we, bus_b.rq0_addr, bus_b.rq0_wdata} = '0;
        {bus_b.rq1_req, bus_b.rq1_we, bus_b.rq1_addr, bus_b.rq1_wdata} = '0;
        step();
        step();
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Reset then idle: every output stays 0 for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            check($sformatf("idle_a_c%0d", i), any_out_a(), 32'd0);
            step();
        end
        check("idle_b", any_out_b(), 32'd0);

        // Port 0 write, addr 8'h10, data 55 (LAT=1). Cycle 0 now.
        bus_a.rq0_req = 1'b1; bus_a.rq0_we = 1'b1;
        bus_a.rq0_addr = 8'h10; bus_a.rq0_wdata = 32'd55;
        step(); // cycle 1
        check("wr_dm_write", {31'd0, bus_a.dm_write}, 32'd1);
        check("wr_dm_read",  {31'd0, bus_a.dm_read},  32'd0);
        check("wr_dm_addr",  {24'd0, bus_a.dm_addr},  32'h10);
        check("wr_dm_wdata", bus_a.dm_wrt_data,       32'd55);
        check("wr_busy",     {31'd0, bus_a.busy},     32'd1);
        check("wr_no_done1", {31'd0, bus_a.rq0_done}, 32'd0);
        bus_a.rq0_req = 1'b0;
        bus_a.rq0_addr = 8'hEE; bus_a.rq0_wdata = 32'd7; // ignored after grant
        step(); // cycle 2
        check("wr_done0",    {31'd0, bus_a.rq0_done}, 32'd1);
        check("wr_done1_lo", {31'd0, bus_a.rq1_done}, 32'd0);
        check("wr_rdata0",   bus_a.rq0_rdata,         32'd0);
        check("wr_dm_off",   {31'd0, bus_a.dm_write}, 32'd0);
        check("wr_addr_off", {24'd0, bus_a.dm_addr},  32'd0);
        step(); // cycle 3
        check("wr_done_end", {31'd0, bus_a.rq0_done}, 32'd0);
        check("wr_idle",     {31'd0, bus_a.busy},     32'd0);

        // LAT=3, port 1 read addr 8'h20, memory returns 99.
        bus_b.rq1_req = 1'b1; bus_b.rq1_we = 1'b0; bus_b.rq1_addr = 8'h20;
        for (int c = 1; c <= 3; c++) begin
            step();
            if (c == 1) bus_b.rq1_req = 1'b0;
            check($sformatf("rdb_read_c%0d", c), {31'd0, bus_b.dm_read}, 32'd1);
            check($sformatf("rdb_addr_c%0d", c), {24'd0, bus_b.dm_addr}, 32'h20);
            check($sformatf("rdb_done_c%0d", c), {31'd0, bus_b.rq1_done}, 32'd0);
        end
        step(); // cycle 4
        check("rdb_done",   {31'd0, bus_b.rq1_done}, 32'd1);
        check("rdb_done0",  {31'd0, bus_b.rq0_done}, 32'd0);
        check("rdb_rdata",  bus_b.rq1_rdata,         32'd99);
        check("rdb_dm_off", {31'd0, bus_b.dm_read},  32'd0);
        step();
        check("rdb_hold",   bus_b.rq1_rdata,         32'd99);

        // Both ports read continuously from reset, LAT=1: 3-cycle period,
        // grants alternate 0,1,0,1.
        rst_a = 1'b0;
        step();
        rst_a = 1'b1;
        bus_a.rq0_req = 1'b1; bus_a.rq0_we = 1'b0; bus_a.rq0_addr = 8'h30;
        bus_a.rq1_req = 1'b1; bus_a.rq1_we = 1'b0; bus_a.rq1_addr = 8'h31;
        for (int c = 1; c <= 11; c++) begin
            int ph;
            int port;
            step();
            ph   = c % 3;
            port = (c / 3) % 2;
            check($sformatf("rr_read_c%0d", c), {31'd0, bus_a.dm_read}, {31'd0, ph == 1});
            check($sformatf("rr_addr_c%0d", c), {24'd0, bus_a.dm_addr},
                  (ph == 1) ? 32'h30 + 32'(port) : 32'd0);
            check($sformatf("rr_done0_c%0d", c), {31'd0, bus_a.rq0_done},
                  {31'd0, ph == 2 && port == 0});
            check($sformatf("rr_done1_c%0d", c), {31'd0, bus_a.rq1_done},
                  {31'd0, ph == 2 && port == 1});
            if (ph == 2)
                check($sformatf("rr_rdata_c%0d", c),
                      port ? bus_a.rq1_rdata : bus_a.rq0_rdata,
                      32'hBEEF_0030 + 32'(port));
        end
        bus_a.rq0_req = 1'b0;
        bus_a.rq1_req = 1'b0;
        step();
        check("rr_stop", {31'd0, bus_a.busy}, 32'd0);

        // Port 0 drops req in cycle 1 of a read; done still pulses at LAT+1.
        bus_a.rq0_req = 1'b1; bus_a.rq0_we = 1'b0; bus_a.rq0_addr = 8'h40;
        step(); // cycle 1
        bus_a.rq0_req = 1'b0;
        check("drop_read", {31'd0, bus_a.dm_read}, 32'd1);
        step(); // cycle 2
        check("drop_done",  {31'd0, bus_a.rq0_done}, 32'd1);
        check("drop_rdata", bus_a.rq0_rdata,         32'hBEEF_0040);
        check("drop_rd1",   bus_a.rq1_rdata,         32'hBEEF_0031);
        step();

        // A later write on port 0 leaves its rdata untouched.
        bus_a.rq0_req = 1'b1; bus_a.rq0_we = 1'b1;
        bus_a.rq0_addr = 8'h41; bus_a.rq0_wdata = 32'h1234_5678;
        step();
        bus_a.rq0_req = 1'b0;
        check("wr2_wdata", bus_a.dm_wrt_data, 32'h1234_5678);
        step();
        check("wr2_done",  {31'd0, bus_a.rq0_done}, 32'd1);
        check("wr2_rdata", bus_a.rq0_rdata,         32'hBEEF_0040);

        // Reset during ACCESS of a read (LAT=3): abort, no done, rdata stays 0.
        rst_b = 1'b0;
        step();
        rst_b = 1'b1;
        bus_b.rq0_req = 1'b1; bus_b.rq0_we = 1'b0; bus_b.rq0_addr = 8'h22;
        step(); // cycle 1, ACCESS
        check("rst_mid_busy", {31'd0, bus_b.busy}, 32'd1);
        step(); // cycle 2, ACCESS
        bus_b.rq0_req = 1'b0;
        rst_b = 1'b0;
        step();
        rst_b = 1'b1;
        check("rst_mid_out", any_out_b(), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("rst_after_c%0d", i), any_out_b(), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
